// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues in-order fetches, tracks outstanding requests,
// discards stale responses after a redirect and queues fetched words for decode.
module prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  output logic [63:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_instr,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  input  logic        Stall_D,
  output logic        Valid_F,
  output logic [31:0] Instr_F,
  output logic [63:0] PC_F
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [63:0]   fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] fifo_count_reg, fifo_count_next;
  logic [OW-1:0] live_cnt_reg, live_cnt_next;
  logic [OW-1:0] drop_cnt_reg, drop_cnt_next;

  logic [63:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  // aq_reg[0] always holds the PC of the oldest live request
  logic [63:0] aq_reg     [MAX_OUT];

  logic accept, resp_live, resp_drop, push, pop;
  int   inflight;

  assign inflight  = int'(live_cnt_reg) + int'(drop_cnt_reg);
  assign req_valid = !rst && !PCSrc_E
                     && (int'(fifo_count_reg) + int'(live_cnt_reg) < DEPTH)
                     && (inflight < MAX_OUT);
  assign req_addr  = fetch_pc_reg;

  assign accept    = req_valid && req_ready;
  assign resp_drop = resp_valid && (drop_cnt_reg != '0);
  // A response with nothing outstanding (e.g. just after reset) is ignored
  assign resp_live = resp_valid && (drop_cnt_reg == '0) && (live_cnt_reg != '0);
  assign push      = resp_live && !PCSrc_E;
  assign pop       = Valid_F && !Stall_D && !PCSrc_E;

  assign Valid_F = (fifo_count_reg != '0);
  assign Instr_F = Valid_F ? fifo_instr[rd_ptr_reg] : 32'h0000_0013;
  assign PC_F    = Valid_F ? fifo_pc[rd_ptr_reg] : 64'h0;

  always_comb begin
    fetch_pc_next   = fetch_pc_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    fifo_count_next = fifo_count_reg;
    live_cnt_next   = live_cnt_reg;
    drop_cnt_next   = drop_cnt_reg;
    if (PCSrc_E) begin
      // Everything in flight becomes stale; a response landing now is already consumed
      fetch_pc_next   = PCTarget_E;
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      fifo_count_next = '0;
      live_cnt_next   = '0;
      drop_cnt_next   = OW'(inflight - int'(resp_valid && (inflight != 0)));
    end else begin
      if (accept) fetch_pc_next = fetch_pc_reg + 64'd4;
      if (push)   wr_ptr_next   = wr_ptr_reg + PW'(1);
      if (pop)    rd_ptr_next   = rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count_next = fifo_count_reg + CW'(1);
        2'b01:   fifo_count_next = fifo_count_reg - CW'(1);
        default: fifo_count_next = fifo_count_reg;
      endcase
      live_cnt_next = live_cnt_reg + OW'(accept) - OW'(resp_live);
      if (resp_drop) drop_cnt_next = drop_cnt_reg - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg   <= RESET_PC;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      live_cnt_reg   <= '0;
      drop_cnt_reg   <= '0;
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      fifo_count_reg <= fifo_count_next;
      live_cnt_reg   <= live_cnt_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_reg]    <= aq_reg[0];
      fifo_instr[wr_ptr_reg] <= resp_instr;
    end
  end

  // Shift queue: a live response retires entry 0, an accept appends behind the last live entry
  generate
    for (genvar gi = 0; gi < MAX_OUT; gi++) begin : gen_aq
      logic [63:0] shift_in;
      if (gi < MAX_OUT - 1) begin : g_mid
        assign shift_in = aq_reg[gi+1];
      end else begin : g_last
        assign shift_in = aq_reg[gi];
      end
      always_ff @(posedge clk) begin
        if (resp_live) begin
          if (accept && (int'(live_cnt_reg) - 1 == gi)) aq_reg[gi] <= fetch_pc_reg;
          else                                          aq_reg[gi] <= shift_in;
        end else if (accept && (int'(live_cnt_reg) == gi)) begin
          aq_reg[gi] <= fetch_pc_reg;
        end
      end
    end
  endgenerate

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_count_reg == CW'(DEPTH))));
`endif

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench for prefetch_buffer: a latency-programmable in-order memory plus
// a stream scoreboard (delivered PCs run consecutively from reset/redirect target).
module tb_prefetch_buffer;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk, rst;
  logic        req_valid, req_ready, resp_valid, PCSrc_E, Stall_D, Valid_F;
  logic [63:0] req_addr, PCTarget_E, PC_F;
  logic [31:0] resp_instr, Instr_F;

  prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_instr(resp_instr),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E), .Stall_D(Stall_D),
    .Valid_F(Valid_F), .Instr_F(Instr_F), .PC_F(PC_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       pend[$];
  int          cyc, n_tests, n_fail, pops;
  logic [63:0] exp_pc, exp_req;
  logic        s_valid_f, s_req_valid, s_resp_valid;
  logic [63:0] s_pc_f, s_req_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive inputs at negedge, sample 1ns later, account for the coming posedge
  task automatic cycle(input logic stall, input logic ready, input logic redir,
                       input logic [63:0] tgt, input int lat);
    @(negedge clk);
    Stall_D = stall; req_ready = ready; PCSrc_E = redir; PCTarget_E = tgt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_instr = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_instr = $urandom;
    end
    #1;
    s_valid_f = Valid_F; s_pc_f = PC_F; s_req_valid = req_valid;
    s_req_addr = req_addr; s_resp_valid = resp_valid;
    if (redir) begin
      n_tests++;
      if (req_valid !== 1'b0) begin
        n_fail++; $display("FAIL req_during_redirect: req_valid=%b required 0", req_valid);
      end
    end
    if (req_valid && ready) begin
      n_tests++;
      if (req_addr !== exp_req) begin
        n_fail++; $display("FAIL req_addr: got %h required %h", req_addr, exp_req);
      end
      pend.push_back('{addr: req_addr, due: cyc + lat});
      exp_req = exp_req + 64'd4;
      n_tests++;
      if (pend.size() > MAX_OUT) begin
        n_fail++; $display("FAIL max_out: in flight %0d required <= %0d", pend.size(), MAX_OUT);
      end
    end
    if (Valid_F && !stall && !redir) begin
      $display("[TB] pop pc=%h instr=%h", PC_F, Instr_F);
      n_tests++;
      if (PC_F !== exp_pc) begin
        n_fail++; $display("FAIL pop_pc: got %h required %h", PC_F, exp_pc);
      end
      n_tests++;
      if (Instr_F !== mem_word(exp_pc)) begin
        n_fail++; $display("FAIL pop_instr: got %h required %h", Instr_F, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 64'd4;
      pops++;
    end
    if (redir) begin
      exp_pc = tgt; exp_req = tgt;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; resp_valid = 1'b0; PCSrc_E = 1'b0; Stall_D = 1'b0; req_ready = 1'b0;
    pend.delete();
    exp_pc = RESET_PC; exp_req = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Search a bounded window for the first valid head and require it to be the target
  task automatic expect_first(input logic [63:0] tgt, input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 3);
      if (s_valid_f) begin
        seen = 1;
        n_tests++;
        if (s_pc_f !== tgt) begin
          n_fail++; $display("FAIL %s: first PC_F %h required %h", name, s_pc_f, tgt);
        end
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: Valid_F=0 after 20 cycles required 1", name);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_tests++;
    if (Valid_F !== 1'b0 || Instr_F !== 32'h0000_0013 || PC_F !== 64'h0) begin
      n_fail++; $display("FAIL reset_head: Valid_F=%b Instr_F=%h PC_F=%h required 0/00000013/0",
                         Valid_F, Instr_F, PC_F);
    end
    n_tests++;
    if (req_valid !== 1'b0 || req_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_req: req_valid=%b req_addr=%h required 0/%h",
                         req_valid, req_addr, RESET_PC);
    end
    rst = 1'b0; #1;
    n_tests++;
    if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_req: req_valid=%b req_addr=%h required 1/%h",
                         req_valid, req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int p0 = 0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i == 6) p0 = pops;
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
    end
    n_tests++;
    if (pops - p0 != 24) begin
      n_fail++; $display("FAIL stream_rate: %0d pops in 24 cycles required 24", pops - p0);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
    n_tests++;
    if (s_valid_f !== 1'b1 || s_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: Valid_F=%b req_valid=%b required 1/0",
                         s_valid_f, s_req_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 64'h0, 1);
      n_tests++;
      if (s_valid_f !== 1'b1) begin
        n_fail++; $display("FAIL fill_drain: Valid_F=%b at pop %0d required 1", s_valid_f, i);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1);
    n_tests++;
    if (s_valid_f !== 1'b0) begin
      n_fail++; $display("FAIL fill_empty: Valid_F=%b required 0", s_valid_f);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 3);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 3);
    cycle(1'b0, 1'b1, 1'b1, 64'h100, 3);
    expect_first(64'h100, "redirect_target");
  endtask

  task automatic test_redirect_resp();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
    cycle(1'b0, 1'b1, 1'b1, 64'h2000, 1);
    n_tests++;
    if (s_resp_valid !== 1'b1 || s_valid_f !== 1'b1) begin
      n_fail++; $display("FAIL redir_setup: resp_valid=%b Valid_F=%b required 1/1",
                         s_resp_valid, s_valid_f);
    end
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
    n_tests++;
    if (s_valid_f !== 1'b0) begin
      n_fail++; $display("FAIL redir_flush: Valid_F=%b required 0", s_valid_f);
    end
    expect_first(64'h2000, "redir_resp_target");
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    n_tests++;
    if (Valid_F !== 1'b0 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: Valid_F=%b req_valid=%b required 0/0", Valid_F, req_valid);
    end
    pend.delete();
    exp_pc = RESET_PC; exp_req = RESET_PC;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; Stall_D = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b1; resp_instr = 32'hDEAD_BEEF; #1;
    n_tests++;
    if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_restart: req_valid=%b req_addr=%h required 1/%h",
                         req_valid, req_addr, RESET_PC);
    end
    @(negedge clk);
    resp_valid = 1'b0; #1;
    n_tests++;
    if (Valid_F !== 1'b0) begin
      n_fail++; $display("FAIL late_resp: Valid_F=%b required 0", Valid_F);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
  endtask

  task automatic test_ready_low();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 64'h0, 1);
      n_tests++;
      if (s_req_addr !== exp_req) begin
        n_fail++; $display("FAIL ready_hold: req_addr=%h required %h", s_req_addr, exp_req);
      end
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 1);
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) == 0, ($urandom % 5) != 0, ($urandom % 25) == 0,
            {$urandom, $urandom}, $urandom_range(1, 4));
    end
    p0 = pops;
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 64'h0, 2);
    n_tests++;
    if (pops == p0) begin
      n_fail++; $display("FAIL random_drain: 0 pops in 15 cycles required > 0");
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; pops = 0; cyc = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    rst = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_instr = '0;
    PCSrc_E = 1'b0; PCTarget_E = '0; Stall_D = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_redirect_resp();
    test_reset_mid();
    test_ready_low();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
